// File: rtl/hwpe_stream_tcdm_load_arbiter_sidech_pkg.sv
// Shared types and defaults for the side-channel TCDM load arbiter and its
// reusable round-robin/lock arbiter core.
package hwpe_stream_tcdm_load_arbiter_sidech_pkg;

    localparam int unsigned HWPE_LOAD_ARB_DEFAULT_MAX_OUTSTANDING = 8;

    typedef struct packed {
        logic busy;
    } arb_flags_t;

    // A stalled request (req without gnt) pins the selection until granted.
    typedef enum logic {
        ARB_FREE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_lock_state_e;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/hwpe_stream_tcdm_load_arbiter_sidech_if.sv
// TCDM request/response port bundle; master issues requests, slave serves them.
interface hwpe_stream_intf_tcdm;

    logic        req;
    logic        gnt;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] r_data;
    logic        r_valid;

    modport master (
        output req, add, wen, be, data,
        input  gnt, r_data, r_valid
    );

    modport slave (
        input  req, add, wen, be, data,
        output gnt, r_data, r_valid
    );

endinterface

// File: rtl/hwpe_stream_tcdm_load_arbiter_sidech_rr_arbiter_lock.sv
// Round-robin arbiter with a lock that holds the selection while the downstream
// port stalls a request; shared by the load and store paths.
module hwpe_stream_rr_arbiter_lock
    import hwpe_stream_tcdm_load_arbiter_sidech_pkg::*;
#(
    parameter int unsigned NB_IN    = 4,
    parameter int unsigned ID_WIDTH = $clog2(NB_IN)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic [NB_IN-1:0]    eligible_i,
    input  logic                gnt_i,
    output logic [ID_WIDTH-1:0] sel_o,
    output logic                valid_o
);

    arb_lock_state_e     state_q;
    logic [ID_WIDTH-1:0] rr_ptr_q;
    logic [ID_WIDTH-1:0] locked_idx_q;
    logic [ID_WIDTH-1:0] free_idx;
    logic                free_found;
    logic [ID_WIDTH-1:0] next_ptr;

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        int unsigned idx;
        idx        = 0;
        free_idx   = '0;
        free_found = 1'b0;
        for (int k = 0; k < NB_IN; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NB_IN) idx = idx - NB_IN;
            if (!free_found && eligible_i[idx[ID_WIDTH-1:0]]) begin
                free_idx   = idx[ID_WIDTH-1:0];
                free_found = 1'b1;
            end
        end
    end

    // A locked index is kept even if it is no longer eligible: the request
    // is already on the bus and its address must not change.
    assign sel_o    = (state_q == ARB_LOCKED) ? locked_idx_q : free_idx;
    assign valid_o  = (state_q == ARB_LOCKED) | free_found;
    assign next_ptr = ID_WIDTH'(wrap_inc(32'(sel_o), NB_IN));

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ARB_FREE;
            rr_ptr_q     <= '0;
            locked_idx_q <= '0;
        end else if (clear_i) begin
            state_q      <= ARB_FREE;
            rr_ptr_q     <= '0;
            locked_idx_q <= '0;
        end else if (valid_o && gnt_i) begin
            state_q  <= ARB_FREE;
            rr_ptr_q <= next_ptr;
        end else if (valid_o) begin
            state_q      <= ARB_LOCKED;
            locked_idx_q <= sel_o;
        end
    end

endmodule

// File: rtl/hwpe_stream_tcdm_load_arbiter_sidech.sv
// Shares one side-channel load FIFO among NB_IN load requesters, tagging requests
// with the requester index. Optional perf counters: define HWPE_LOAD_ARB_PERF_EN.
module hwpe_stream_tcdm_load_arbiter_sidech
    import hwpe_stream_tcdm_load_arbiter_sidech_pkg::*;
#(
    parameter int unsigned NB_IN           = 4,
    parameter int unsigned MAX_OUTSTANDING = HWPE_LOAD_ARB_DEFAULT_MAX_OUTSTANDING,
    parameter int unsigned ID_WIDTH        = $clog2(NB_IN)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    output logic                  busy_o,
    hwpe_stream_intf_tcdm.slave   tcdm_slave [NB_IN],
    input  logic [NB_IN-1:0]      r_ready_i,
    hwpe_stream_intf_tcdm.master  tcdm_master,
    output logic [ID_WIDTH-1:0]   sidech_o,
    input  logic [ID_WIDTH-1:0]   sidech_i,
    output logic                  ready_o
`ifdef HWPE_LOAD_ARB_PERF_EN
  , output logic [NB_IN-1:0][31:0] perf_grant_o
  , output logic [31:0]            perf_stall_o
`endif
);

    localparam int unsigned          CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(MAX_OUTSTANDING);

    logic [NB_IN-1:0]     slv_req;
    logic [NB_IN-1:0]     eligible;
    logic [NB_IN-1:0]     inc;
    logic [NB_IN-1:0]     dec;
    logic [NB_IN-1:0]     cnt_nz;
    logic [31:0]          slv_add [NB_IN];
    logic [CNT_WIDTH-1:0] cnt_q   [NB_IN];
    logic [ID_WIDTH-1:0]  sel;
    logic                 sel_valid;
    logic                 handshake;
    logic                 tag_ok;
    logic                 pop;
    arb_flags_t           flags;

    for (genvar i = 0; i < NB_IN; i++) begin : gen_slave
        assign slv_req[i]  = tcdm_slave[i].req;
        assign slv_add[i]  = tcdm_slave[i].add;
        assign eligible[i] = slv_req[i] & (cnt_q[i] < CNT_MAX);
        assign cnt_nz[i]   = |cnt_q[i];
        assign inc[i]      = handshake & (sel == ID_WIDTH'(i));
        assign dec[i]      = pop & (sidech_i == ID_WIDTH'(i));

        assign tcdm_slave[i].gnt     = sel_valid & (sel == ID_WIDTH'(i)) & tcdm_master.gnt;
        assign tcdm_slave[i].r_valid = tcdm_master.r_valid & tag_ok & (sidech_i == ID_WIDTH'(i));
        assign tcdm_slave[i].r_data  = tcdm_master.r_data;
    end

    hwpe_stream_rr_arbiter_lock #(
        .NB_IN    (NB_IN),
        .ID_WIDTH (ID_WIDTH)
    ) i_arbiter (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (clear_i),
        .eligible_i (eligible),
        .gnt_i      (tcdm_master.gnt),
        .sel_o      (sel),
        .valid_o    (sel_valid)
    );

    // Loads only: the store fields are tied off.
    assign tcdm_master.req  = sel_valid;
    assign tcdm_master.add  = slv_add[sel];
    assign tcdm_master.wen  = 1'b1;
    assign tcdm_master.be   = '1;
    assign tcdm_master.data = '0;
    assign sidech_o         = sel;
    assign handshake        = sel_valid & tcdm_master.gnt;

    // An out-of-range tag has no owner; pop it so the FIFO cannot block.
    assign tag_ok  = 32'(sidech_i) < NB_IN;
    assign ready_o = tcdm_master.r_valid & (~tag_ok | r_ready_i[sidech_i]);
    assign pop     = tcdm_master.r_valid & ready_o & tag_ok;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NB_IN; i++) cnt_q[i] <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < NB_IN; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NB_IN; i++) begin
                if (inc[i] && !dec[i] && cnt_q[i] != CNT_MAX) begin
                    cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
                end else if (dec[i] && !inc[i] && cnt_nz[i]) begin
                    cnt_q[i] <= cnt_q[i] - CNT_WIDTH'(1);
                end
            end
        end
    end

    assign flags.busy = (|slv_req) | (|cnt_nz);
    assign busy_o     = flags.busy;

`ifdef HWPE_LOAD_ARB_PERF_EN
    logic [NB_IN-1:0][31:0] perf_grant_q;
    logic [31:0]            perf_stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_grant_q <= '0;
            perf_stall_q <= '0;
        end else if (clear_i) begin
            perf_grant_q <= '0;
            perf_stall_q <= '0;
        end else begin
            for (int i = 0; i < NB_IN; i++) begin
                if (inc[i]) perf_grant_q[i] <= perf_grant_q[i] + 32'd1;
            end
            if (sel_valid && !tcdm_master.gnt) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_grant_o = perf_grant_q;
    assign perf_stall_o = perf_stall_q;
`endif

`ifndef SYNTHESIS
    for (genvar i = 0; i < NB_IN; i++) begin : gen_cnt_assert
        a_cnt_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
            (inc[i] && !dec[i]) |-> (cnt_q[i] != CNT_MAX));
        a_cnt_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
            (dec[i] && !inc[i]) |-> cnt_nz[i]);
    end

    a_tag_range: assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
        tcdm_master.r_valid |-> tag_ok);
`endif

endmodule

// File: tb/tb_hwpe_stream_tcdm_load_arbiter_sidech.sv
// Scoreboard bench for the side-channel load arbiter: stimulus pushes expected
// grants/responses, an independent monitor pops and compares them.
module tb_hwpe_stream_tcdm_load_arbiter_sidech;

    localparam int unsigned NB_IN    = 4;
    localparam int unsigned ID_WIDTH = 2;

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [31:0]         add;
    } gnt_exp_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [31:0]         data;
    } rsp_exp_t;

    logic clk    = 1'b0;
    logic rst_ni = 1'b0;
    logic clear_i = 1'b0;

    always #5 clk = ~clk;

    logic                busy_o;
    logic                ready_o;
    logic [NB_IN-1:0]    r_ready_i;
    logic [ID_WIDTH-1:0] sidech_o;
    logic [ID_WIDTH-1:0] sidech_i;
    logic [NB_IN-1:0]    req_d;
    logic [31:0]         add_d   [NB_IN];
    logic [NB_IN-1:0]    s_gnt;
    logic [NB_IN-1:0]    s_rvalid;
    logic [31:0]         s_rdata [NB_IN];
`ifdef HWPE_LOAD_ARB_PERF_EN
    logic [NB_IN-1:0][31:0] perf_grant_o;
    logic [31:0]            perf_stall_o;
`endif

    hwpe_stream_intf_tcdm slv [NB_IN] ();
    hwpe_stream_intf_tcdm mst ();

    for (genvar g = 0; g < NB_IN; g++) begin : g_slv
        assign slv[g].req  = req_d[g];
        assign slv[g].add  = add_d[g];
        assign slv[g].wen  = 1'b1;
        assign slv[g].be   = '1;
        assign slv[g].data = '0;
        assign s_gnt[g]    = slv[g].gnt;
        assign s_rvalid[g] = slv[g].r_valid;
        assign s_rdata[g]  = slv[g].r_data;
    end

    hwpe_stream_tcdm_load_arbiter_sidech #(
        .NB_IN           (NB_IN),
        .MAX_OUTSTANDING (8),
        .ID_WIDTH        (ID_WIDTH)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .busy_o      (busy_o),
        .tcdm_slave  (slv),
        .r_ready_i   (r_ready_i),
        .tcdm_master (mst),
        .sidech_o    (sidech_o),
        .sidech_i    (sidech_i),
        .ready_o     (ready_o)
`ifdef HWPE_LOAD_ARB_PERF_EN
      , .perf_grant_o (perf_grant_o)
      , .perf_stall_o (perf_stall_o)
`endif
    );

    int errors = 0;
    int checks = 0;

    gnt_exp_t gnt_q[$];
    rsp_exp_t rsp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    function automatic logic [31:0] addr_of(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h100;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_gnt(input int id);
        gnt_q.push_back('{id: ID_WIDTH'(id), add: addr_of(id)});
    endtask

    // Present one response and hold it until the arbiter pops it.
    task automatic send_rsp(input int id, input logic [31:0] data);
        int n;
        mst.r_valid = 1'b1;
        sidech_i    = ID_WIDTH'(id);
        mst.r_data  = data;
        rsp_q.push_back('{id: ID_WIDTH'(id), data: data});
        n = 0;
        forever begin
            @(negedge clk);
            if (ready_o) break;
            n++;
            if (n > 50) begin
                fail("rsp_pop_timeout");
                break;
            end
        end
        tick();
        mst.r_valid = 1'b0;
    endtask

    // Monitor: compares every handshake the DUT presents against the queues.
    initial begin
        gnt_exp_t g;
        rsp_exp_t r;
        forever begin
            @(negedge clk);
            if (rst_ni) begin
                if (mst.req && mst.gnt) begin
                    if (gnt_q.size() == 0) begin
                        fail("unexpected_grant");
                    end else begin
                        g = gnt_q.pop_front();
                        check("grant_sidech", 32'(sidech_o), 32'(g.id));
                        check("grant_add", mst.add, g.add);
                        check("grant_slave_gnt", 32'(s_gnt), 32'(4'b0001 << g.id));
                    end
                end else if (s_gnt != '0) begin
                    check("spurious_slave_gnt", 32'(s_gnt), 32'd0);
                end
                if (mst.r_valid || s_rvalid != '0)
                    check("rvalid_onehot", $countones(s_rvalid), mst.r_valid ? 32'd1 : 32'd0);
                for (int k = 0; k < NB_IN; k++) begin
                    if (s_rvalid[k] && r_ready_i[k]) begin
                        if (rsp_q.size() == 0) begin
                            fail("unexpected_response");
                        end else begin
                            r = rsp_q.pop_front();
                            check("rsp_slave", 32'(k), 32'(r.id));
                            check("rsp_data", s_rdata[k], r.data);
                            check("rsp_ready_o", 32'(ready_o), 32'd1);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        req_d       = '0;
        r_ready_i   = '1;
        sidech_i    = '0;
        mst.gnt     = 1'b0;
        mst.r_valid = 1'b0;
        mst.r_data  = '0;
        for (int i = 0; i < NB_IN; i++) add_d[i] = addr_of(i);

        repeat (2) tick();
        check("rst_req", 32'(mst.req), 32'd0);
        check("rst_slave_gnt", 32'(s_gnt), 32'd0);
        check("rst_rvalid", 32'(s_rvalid), 32'd0);
        check("rst_ready", 32'(ready_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        rst_ni = 1'b1;
        tick();

        // Round-robin alternation between 0 and 2.
        mst.gnt  = 1'b1;
        req_d[0] = 1'b1;
        req_d[2] = 1'b1;
        exp_gnt(0); exp_gnt(2); exp_gnt(0); exp_gnt(2);
        repeat (4) tick();
        req_d = '0;
        send_rsp(0, 32'hD000_0001);
        send_rsp(2, 32'hD000_0002);
        send_rsp(0, 32'hD000_0003);
        send_rsp(2, 32'hD000_0004);

        // Stalled request on 1 stays locked while 3 arrives.
        mst.gnt  = 1'b0;
        req_d[1] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("lock_sidech", 32'(sidech_o), 32'd1);
            check("lock_add", mst.add, addr_of(1));
            check("lock_req", 32'(mst.req), 32'd1);
            tick();
            if (c == 0) req_d[3] = 1'b1;
        end
        mst.gnt = 1'b1;
        exp_gnt(1); exp_gnt(3);
        tick();
        req_d[1] = 1'b0;
        tick();
        req_d[3] = 1'b0;
        send_rsp(1, 32'hD100_0001);
        send_rsp(3, 32'hD300_0001);

        // Outstanding limit: 8 grants, 9th blocked until a response is popped.
        req_d[0] = 1'b1;
        repeat (8) exp_gnt(0);
        repeat (8) tick();
        @(negedge clk);
        check("full_req", 32'(mst.req), 32'd0);
        check("full_gnt0", 32'(s_gnt[0]), 32'd0);
        check("full_busy", 32'(busy_o), 32'd1);
        tick();
        mst.r_valid = 1'b1;
        sidech_i    = 2'd0;
        mst.r_data  = 32'hE000_0000;
        rsp_q.push_back('{id: 2'd0, data: 32'hE000_0000});
        @(negedge clk);
        check("pop_cycle_req", 32'(mst.req), 32'd0);
        tick();
        mst.r_valid = 1'b0;
        exp_gnt(0);
        tick();
        req_d[0] = 1'b0;
        for (int i = 1; i < 8; i++) send_rsp(0, 32'hE000_0000 + 32'(i));

        // Response for 2 back-pressured for two cycles, then one for 0.
        req_d[2] = 1'b1;
        exp_gnt(2);
        tick();
        req_d[2]     = 1'b0;
        r_ready_i[2] = 1'b0;
        mst.r_valid  = 1'b1;
        sidech_i     = 2'd2;
        mst.r_data   = 32'hA200_0000;
        rsp_q.push_back('{id: 2'd2, data: 32'hA200_0000});
        repeat (2) begin
            @(negedge clk);
            check("hold_ready", 32'(ready_o), 32'd0);
            check("hold_rvalid", 32'(s_rvalid), 32'b0100);
            tick();
        end
        r_ready_i[2] = 1'b1;
        tick();
        sidech_i   = 2'd0;
        mst.r_data = 32'hA000_0000;
        rsp_q.push_back('{id: 2'd0, data: 32'hA000_0000});
        tick();
        mst.r_valid = 1'b0;
        @(negedge clk);
        check("drained_busy", 32'(busy_o), 32'd0);
        tick();

        // Grant and pop on index 1 in the same cycle leaves its count at 1.
        req_d[1] = 1'b1;
        exp_gnt(1);
        tick();
        mst.r_valid = 1'b1;
        sidech_i    = 2'd1;
        mst.r_data  = 32'hB100_0000;
        rsp_q.push_back('{id: 2'd1, data: 32'hB100_0000});
        exp_gnt(1);
        tick();
        req_d[1]    = 1'b0;
        mst.r_valid = 1'b0;
        @(negedge clk);
        check("same_idx_busy", 32'(busy_o), 32'd1);
        tick();
        send_rsp(1, 32'hB100_0001);
        @(negedge clk);
        check("same_idx_drained", 32'(busy_o), 32'd0);
        tick();

        // Clear mid-burst with a locked request pending.
        req_d[0] = 1'b1;
        req_d[2] = 1'b1;
        exp_gnt(2); exp_gnt(0);
        repeat (2) tick();
        mst.gnt = 1'b0;
        tick();
        clear_i = 1'b1;
        req_d   = '0;
        tick();
        clear_i = 1'b0;
        @(negedge clk);
        check("clear_busy", 32'(busy_o), 32'd0);
        check("clear_req", 32'(mst.req), 32'd0);
        tick();
        mst.gnt  = 1'b1;
        req_d[0] = 1'b1;
        req_d[2] = 1'b1;
        exp_gnt(0); exp_gnt(2);
        repeat (2) tick();
        req_d = '0;
        send_rsp(0, 32'hC000_0000);
        send_rsp(2, 32'hC200_0000);
        @(negedge clk);
        check("post_clear_busy", 32'(busy_o), 32'd0);
        tick();

`ifdef HWPE_LOAD_ARB_PERF_EN
        clear_i = 1'b1;
        tick();
        clear_i  = 1'b0;
        req_d[3] = 1'b1;
        mst.gnt  = 1'b0;
        repeat (2) tick();
        mst.gnt = 1'b1;
        repeat (5) exp_gnt(3);
        repeat (5) tick();
        req_d[3] = 1'b0;
        @(negedge clk);
        check("perf_grant3", perf_grant_o[3], 32'd5);
        check("perf_grant0", perf_grant_o[0], 32'd0);
        check("perf_stall", perf_stall_o, 32'd2);
        tick();
        for (int i = 0; i < 5; i++) send_rsp(3, 32'hF300_0000 + 32'(i));
`endif

        repeat (3) tick();
        check("gnt_queue_empty", 32'(gnt_q.size()), 32'd0);
        check("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
